// File: rtl/axilite_csr_write_ctrl_pkg.sv
// Shared types and address decode helper for the AXI-Lite CSR controllers.
package axilite_csr_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } wctrl_state_t;

  // Operands are zero-extended to 64 bits; the base check rules out wrap on subtraction.
  function automatic logic csr_addr_in_range(input logic [63:0] addr,
                                             input logic [63:0] base,
                                             input int unsigned num_regs);
    logic [63:0] offset;
    offset = addr - base;
    return (addr >= base) && ((offset >> 2) < 64'(num_regs)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/axilite_csr_write_ctrl_if.sv
// AXI-Lite write address/data/response channels.
interface axilite_csr_write_ctrl_if
  import axilite_csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  resp_t               s_bresp;
  logic                s_bvalid;
  logic                s_bready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axilite_csr_write_ctrl_addr_decode.sv
// Combinational CSR window check: in range and word aligned.
module axilite_csr_addr_decode
  import axilite_csr_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       NUM_REGS  = 16
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              good
);
  assign good = csr_addr_in_range(64'(addr), 64'(BASE_ADDR), NUM_REGS);
endmodule

// File: rtl/axilite_csr_write_ctrl.sv
// AXI-Lite write controller: collects AW/W, runs one write into the CSR data
// stage with a completion timeout, then returns the B response.
module axilite_csr_write_ctrl
  import axilite_csr_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned       NUM_REGS       = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  axilite_csr_write_ctrl_if.slave  s_axi,
  output logic [ADDR_W-1:0]        csr_addr,
  output logic                     csr_addr_good,
  output logic [DATA_W-1:0]        csr_wdata,
  output logic [DATA_W/8-1:0]      csr_wstrb,
  output logic                     csr_wvalid,
  input  logic                     csr_wready,
  input  logic                     csr_deassert_addr
);
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  wctrl_state_t        state_reg;
  logic                aw_held_reg;
  logic                w_held_reg;
  logic                awready_reg;
  logic                wready_reg;
  logic                bvalid_reg;
  resp_t               bresp_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic                good_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W/8-1:0] wstrb_reg;
  logic                wvalid_reg;

  logic decode_good;
  logic aw_fire;
  logic w_fire;
  logic aw_have;
  logic w_have;
  logic txn_good;

  axilite_csr_addr_decode #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS)
  ) u_decode (
    .addr (s_axi.s_awaddr),
    .good (decode_good)
  );

  assign aw_fire  = s_axi.s_awvalid && awready_reg;
  assign w_fire   = s_axi.s_wvalid && wready_reg;
  assign aw_have  = aw_held_reg || aw_fire;
  assign w_have   = w_held_reg || w_fire;
  // The decode of a beat captured this very cycle is not in good_reg yet.
  assign txn_good = aw_fire ? decode_good : good_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      timer_reg   <= '0;
      addr_reg    <= '0;
      good_reg    <= 1'b0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      wvalid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (aw_fire) begin
            addr_reg    <= s_axi.s_awaddr;
            good_reg    <= decode_good;
            aw_held_reg <= 1'b1;
          end
          if (w_fire) begin
            wdata_reg  <= s_axi.s_wdata;
            wstrb_reg  <= s_axi.s_wstrb;
            w_held_reg <= 1'b1;
          end
          if (aw_have && w_have) begin
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            if (txn_good) begin
              state_reg  <= EXEC;
              wvalid_reg <= 1'b1;
              timer_reg  <= '0;
            end else begin
              state_reg  <= RESP;
              bvalid_reg <= 1'b1;
              bresp_reg  <= RESP_SLVERR;
            end
          end else begin
            // Ready rises only from inside IDLE, so the first IDLE cycle after B stays closed.
            awready_reg <= !aw_have;
            wready_reg  <= !w_have;
          end
        end
        EXEC: begin
          timer_reg <= timer_reg + 1'b1;
          if (csr_wready) begin
            state_reg  <= RESP;
            wvalid_reg <= 1'b0;
            bvalid_reg <= 1'b1;
            bresp_reg  <= RESP_OKAY;
          end else if (csr_deassert_addr || (timer_reg == TIMER_LAST)) begin
            state_reg  <= RESP;
            wvalid_reg <= 1'b0;
            bvalid_reg <= 1'b1;
            bresp_reg  <= RESP_SLVERR;
          end
        end
        RESP: begin
          if (s_axi.s_bready) begin
            state_reg   <= IDLE;
            bvalid_reg  <= 1'b0;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            good_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_axi.s_awready = awready_reg;
  assign s_axi.s_wready  = wready_reg;
  assign s_axi.s_bvalid  = bvalid_reg;
  assign s_axi.s_bresp   = bresp_reg;
  assign csr_addr        = addr_reg;
  assign csr_addr_good   = good_reg;
  assign csr_wdata       = wdata_reg;
  assign csr_wstrb       = wstrb_reg;
  assign csr_wvalid      = wvalid_reg;
endmodule
